// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, queue entry type and PC step helper for the fetch stage.
// Rev 1.0
`default_nettype none

package fetch_pkg;

  localparam int unsigned         XLEN_DEF     = 32;
  localparam int unsigned         ILEN_DEF     = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned         PC_STEP_DEF  = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN_DEF-1:0] pc_next(input logic [XLEN_DEF-1:0] pc);
    return pc + XLEN_DEF'(PC_STEP_DEF);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/flush; head reads as zero when empty.
// Rev 1.0
`default_nettype none

module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i));

endmodule

`default_nettype wire

// File: rtl/fetch_buffered.sv
// fetch_buffered: credit-limited instruction fetch with in-order responses, decode queue and redirect flush.
// Rev 1.0
`default_nettype none

module fetch_buffered
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = XLEN_DEF,
  parameter int unsigned     ILEN            = ILEN_DEF,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF),
  parameter int unsigned     PC_STEP         = PC_STEP_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [ILEN-1:0] i_imem_rdata,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [ILEN-1:0] o_instr
);

  localparam int unsigned     CW   = $clog2(DEPTH+1);
  localparam int unsigned     OW   = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned     SW   = ((CW > OW) ? CW : OW) + 1;
  localparam int unsigned     EW   = XLEN + ILEN;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_rdata;

  logic credit, req, acc, resp, drop, push, pop;

  always_comb begin
    credit = (SW'(outstanding_q) + SW'(fifo_count) < SW'(DEPTH))
          && (outstanding_q < OW'(MAX_OUTSTANDING))
          && !fifo_full;
    req    = !i_redirect && credit;
    acc    = req && i_imem_gnt;
    // A response with nothing outstanding is unexpected and has no effect.
    resp   = i_imem_rvalid && (outstanding_q != '0);
    drop   = resp && (discard_q != '0);
    push   = resp && !drop && !i_redirect;
    pop    = !fifo_empty && i_ready && !i_redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q;
    if (acc && !resp)      outstanding_d = outstanding_q + OW'(1);
    else if (!acc && resp) outstanding_d = outstanding_q - OW'(1);

    if (i_redirect) begin
      fetch_pc_d = i_redirect_pc;
      resp_pc_d  = i_redirect_pc;
      discard_d  = resp ? (outstanding_q - OW'(1)) : outstanding_q;
    end else begin
      if (acc)  fetch_pc_d = fetch_pc_q + STEP;
      if (drop) discard_d  = discard_q - OW'(1);
      if (push) resp_pc_d  = resp_pc_q + STEP;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (i_redirect),
    .wdata_i ({resp_pc_q, i_imem_rdata}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_imem_req  = req;
  assign o_imem_addr = fetch_pc_q;
  assign o_valid     = !fifo_empty;
  assign o_pc        = fifo_rdata[EW-1:ILEN];
  assign o_instr     = fifo_rdata[ILEN-1:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffered.sv
// tb_fetch_buffered: randomized stimulus against a request-tracking reference model of fetch_buffered.
// Rev 1.0
`default_nettype none

module tb_fetch_buffered;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] instr;

  always #5 clk = ~clk;

  fetch_buffered #(
    .XLEN            (32),
    .ILEN            (32),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (32'h0000_0000),
    .PC_STEP         (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_pc          (pc),
    .o_instr       (instr)
  );

  // Reference model: each accepted request is remembered with its address;
  // a redirect marks everything still in flight as stale.
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } infl_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } memreq_t;

  fetch_entry_t m_q[$];
  infl_t        m_infl[$];
  logic [31:0]  m_fetch_pc = RESET_PC_DEF;
  memreq_t      memq[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int          p_gnt = 100, p_ready = 100, p_redir = 0, p_rsp = 100;
  bit          fixed_lat = 1'b1;
  bit          rst_req = 1'b0;
  bit          drain = 1'b0;
  logic [31:0] redir_base = 32'h0000_0100;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      bit          exp_req;
      bit          granted;
      bit          got_resp;
      logic [31:0] gaddr;
      infl_t       e;
      fetch_entry_t ent;

      @(negedge clk);
      if (drain && memq.size() == 0) drain = 1'b0;
      rst_n       = !rst_req;
      redirect    = (p_redir > 0) && ($urandom_range(99) < p_redir);
      redirect_pc = redir_base + ($urandom_range(15) << 2);
      ready       = $urandom_range(99) < p_ready;
      gnt         = !drain && ($urandom_range(99) < p_gnt);
      rvalid      = 1'b0;
      rdata       = '0;
      if (memq.size() > 0 && memq[0].due <= cyc &&
          (fixed_lat || $urandom_range(99) < p_rsp)) begin
        rvalid = 1'b1;
        rdata  = mem_data(memq[0].addr);
      end
      #1;
      exp_req = !redirect && (m_infl.size() + m_q.size() < DEPTH) && (m_infl.size() < MAXO);
      check("imem_req",  32'(imem_req), 32'(exp_req));
      check("imem_addr", imem_addr, m_fetch_pc);
      check("valid",     32'(valid), 32'(m_q.size() != 0));
      check("pc",        pc,    (m_q.size() != 0) ? m_q[0].pc    : 32'h0);
      check("instr",     instr, (m_q.size() != 0) ? m_q[0].instr : 32'h0);
      granted = imem_req && gnt;
      gaddr   = imem_addr;

      @(posedge clk);
      if (rvalid) void'(memq.pop_front());
      if (granted) memq.push_back('{addr: gaddr, due: cyc + 1 + (fixed_lat ? 0 : int'($urandom_range(2)))});

      if (!rst_n) begin
        m_q.delete();
        m_infl.delete();
        m_fetch_pc = RESET_PC_DEF;
      end else begin
        got_resp = rvalid && (m_infl.size() > 0);
        if (got_resp) e = m_infl.pop_front();
        if (redirect) begin
          m_q.delete();
          foreach (m_infl[i]) m_infl[i].stale = 1'b1;
          m_fetch_pc = redirect_pc;
        end else begin
          if (m_q.size() != 0 && ready) void'(m_q.pop_front());
          if (got_resp && !e.stale) begin
            ent.pc    = e.pc;
            ent.instr = rdata;
            m_q.push_back(ent);
          end
          if (exp_req && gnt) begin
            m_infl.push_back('{pc: m_fetch_pc, stale: 1'b0});
            m_fetch_pc = pc_next(m_fetch_pc);
          end
        end
      end
      cyc++;
    end
  endtask

  task automatic pulse_reset();
    rst_req = 1'b1;
    run_cycles(1);
    rst_req = 1'b0;
    // Responses to pre-reset grants still arrive; hold off new grants until they drain.
    drain   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    // Streaming with single-cycle memory latency.
    p_gnt = 100; p_ready = 100; p_redir = 0; fixed_lat = 1'b1;
    run_cycles(30);

    // Decode stall fills the queue, then release.
    p_ready = 0;
    run_cycles(15);
    p_ready = 100;
    run_cycles(20);

    // Random grants, latency, back-pressure and redirects.
    p_gnt = 70; p_ready = 60; p_redir = 8; p_rsp = 60; fixed_lat = 1'b0;
    redir_base = 32'h0000_0100;
    run_cycles(400);

    // Redirects near the top of the address space to exercise wrap.
    redir_base = 32'hFFFF_FFC0; p_redir = 3; p_gnt = 90; p_ready = 80;
    run_cycles(200);

    // Mid-operation resets with late responses.
    redir_base = 32'h0000_2000; p_redir = 5; p_ready = 30;
    for (int r = 0; r < 6; r++) begin
      run_cycles(25);
      pulse_reset();
    end
    run_cycles(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
